// File: rtl/vga_sync_conditioner.sv
// VGA output conditioner: equal-latency sync/data pipe, frame-synchronous
// polarity switching, active-video blanking and hsync-loss watchdog.
module vga_sync_conditioner #(
    parameter int DELAY        = 2,
    parameter int RGB_W        = 12,
    parameter bit HPOL_DEFAULT = 1'b0,
    parameter bit VPOL_DEFAULT = 1'b1,
    parameter int TIMEOUT      = 2048
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    input  logic [RGB_W-1:0] rgb,
    input  logic             cfg_valid,
    input  logic             cfg_hpol,
    input  logic             cfg_vpol,
    output logic             hsynco,
    output logic             vsynco,
    output logic             deo,
    output logic [RGB_W-1:0] rgbo,
    output logic             frame_start,
    output logic             cfg_pending,
    output logic             sync_lost
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } cfg_state_t;

    logic [DELAY-1:0] hs_s;
    logic [DELAY-1:0] vs_s;
    logic [DELAY-1:0] de_s;
    logic [RGB_W-1:0] rgb_s [DELAY];

    logic       vs_enter;
    logic       edge_e;
    logic       apply;
    cfg_state_t state;
    cfg_state_t state_nx;
    logic       pend_hpol;
    logic       pend_vpol;
    logic       act_hpol;
    logic       act_vpol;

    logic          hs_prev;
    logic          hs_rise;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_s <= '0;
            vs_s <= '0;
            de_s <= '0;
            for (int i = 0; i < DELAY; i++) begin
                rgb_s[i] <= '0;
            end
        end else begin
            for (int i = DELAY - 1; i > 0; i--) begin
                hs_s[i]  <= hs_s[i-1];
                vs_s[i]  <= vs_s[i-1];
                de_s[i]  <= de_s[i-1];
                rgb_s[i] <= rgb_s[i-1];
            end
            hs_s[0]  <= hsync;
            vs_s[0]  <= vsync;
            de_s[0]  <= de;
            rgb_s[0] <= rgb;
        end
    end

    // vsync value about to be loaded into the output stage
    generate
        if (DELAY == 1) begin : g_enter_d1
            assign vs_enter = vsync;
        end else begin : g_enter_dn
            assign vs_enter = vs_s[DELAY-2];
        end
    endgenerate

    assign edge_e = vs_enter & ~vs_s[DELAY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (cfg_valid) begin
                    state_nx = PEND;
                end
            end
            PEND: begin
                if (edge_e && !cfg_valid) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cfg_pending = (state == PEND);
        apply       = (state == PEND) && edge_e;
    end

    // act takes the old pending value when a new request lands on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_hpol   <= 1'b0;
            pend_vpol   <= 1'b0;
            act_hpol    <= HPOL_DEFAULT;
            act_vpol    <= VPOL_DEFAULT;
            frame_start <= 1'b0;
        end else begin
            if (cfg_valid) begin
                pend_hpol <= cfg_hpol;
                pend_vpol <= cfg_vpol;
            end
            if (apply) begin
                act_hpol <= pend_hpol;
                act_vpol <= pend_vpol;
            end
            frame_start <= edge_e;
        end
    end

    assign hs_rise = hsync & ~hs_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_prev   <= 1'b0;
            cnt       <= '0;
            sync_lost <= 1'b0;
        end else begin
            hs_prev <= hsync;
            if (hs_rise) begin
                cnt       <= '0;
                sync_lost <= 1'b0;
            end else if (cnt != CW'(TIMEOUT)) begin
                cnt <= cnt + CW'(1);
                if (cnt == CW'(TIMEOUT - 1)) begin
                    sync_lost <= 1'b1;
                end
            end
        end
    end

    assign hsynco = hs_s[DELAY-1] ^ act_hpol;
    assign vsynco = vs_s[DELAY-1] ^ act_vpol;
    assign deo    = de_s[DELAY-1];
    assign rgbo   = (de_s[DELAY-1] && !sync_lost) ? rgb_s[DELAY-1] : '0;

endmodule
